// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter.
// Default widths are used only when no build-level macro overrides them.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 5
`endif

package wb_pkg;

  typedef enum logic [1:0] {
    WB_SRC_ALU = 2'd0,
    WB_SRC_MEM = 2'd1,
    WB_SRC_MUL = 2'd2
  } wb_src_t;

  localparam int NUM_WB_SOURCES = 3;

  // A source is flagged when it is denied again after this many waits.
  localparam logic [1:0] WAIT_LIMIT = 2'd3;

  function automatic wb_src_t grant_to_src(input logic [NUM_WB_SOURCES-1:0] grant);
    wb_src_t src;
    case (grant)
      3'b001:  src = WB_SRC_ALU;
      3'b010:  src = WB_SRC_MEM;
      3'b100:  src = WB_SRC_MUL;
      default: src = WB_SRC_ALU;
    endcase
    return src;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: one-hot grant chosen by scanning requests from a
// rotating priority pointer that moves just past each winner.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW:0] N_EXT = (PW+1)'(N);

  logic [PW-1:0] ptr_r;
  logic [PW-1:0] win_idx_s;
  logic          found_s;
  logic          hit_s;
  logic [N-1:0]  grant_s;
  logic [PW:0]   sum_s;
  logic [PW:0]   idx_s;

  // Scan from the pointer, wrapping once, and keep the first requester found.
  always_comb begin
    grant_s   = {N{1'b0}};
    win_idx_s = {PW{1'b0}};
    found_s   = 1'b0;
    hit_s     = 1'b0;
    sum_s     = {(PW+1){1'b0}};
    idx_s     = {(PW+1){1'b0}};
    for (int i = 0; i < N; i++) begin
      sum_s = {1'b0, ptr_r} + (PW+1)'(i);
      idx_s = (sum_s >= N_EXT) ? (sum_s - N_EXT) : sum_s;
      hit_s = !found_s && req[idx_s[PW-1:0]];
      grant_s[idx_s[PW-1:0]] = grant_s[idx_s[PW-1:0]] | hit_s;
      win_idx_s = hit_s ? idx_s[PW-1:0] : win_idx_s;
      found_s   = found_s | hit_s;
    end
  end

  // Pointer holds when idle; clear returns priority to source 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r <= {PW{1'b0}};
    end else if (clear) begin
      ptr_r <= {PW{1'b0}};
    end else if (found_s) begin
      ptr_r <= (win_idx_s == PW'(N-1)) ? {PW{1'b0}} : (win_idx_s + PW'(1'b1));
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign grant = grant_s;

endmodule

// File: rtl/wb_arbiter_chk.sv
// Protocol checker for the writeback arbiter grant and writeback behaviour.
module wb_arbiter_chk
  import wb_pkg::*;
(
  input logic                      clk,
  input logic                      rst,
  input logic                      flush,
  input logic [NUM_WB_SOURCES-1:0] valid,
  input logic [NUM_WB_SOURCES-1:0] ready,
  input logic                      wb_valid,
  input logic                      wb_exception,
  input logic [1:0]                wb_src,
  input logic                      starve_err
);

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst)
    $onehot0(ready));

  a_ready_needs_valid: assert property (@(posedge clk) disable iff (!rst)
    ((ready & ~valid) == 3'b000));

  a_flush_blocks: assert property (@(posedge clk) disable iff (!rst)
    flush |-> (ready == 3'b000));

  a_grant_writes_back: assert property (@(posedge clk) disable iff (!rst)
    (|ready) |=> wb_valid);

  a_idle_no_writeback: assert property (@(posedge clk) disable iff (!rst)
    !(|ready) |=> !wb_valid);

  a_exception_from_mem: assert property (@(posedge clk) disable iff (!rst)
    (wb_valid && wb_exception) |-> (wb_src == WB_SRC_MEM));

  a_starve_sticky: assert property (@(posedge clk) disable iff (!rst)
    starve_err |=> starve_err);

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin selection among ALU, MEM and MUL results onto
// one registered writeback port, with flush and starvation monitoring.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 5
`endif

module wb_arbiter #(
  parameter int WORD_SIZE       = `WORD_SIZE,
  parameter int ROB_ENTRY_WIDTH = `ROB_ENTRY_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       alu_valid,
  input  logic [WORD_SIZE-1:0]       alu_result,
  input  logic [ROB_ENTRY_WIDTH-1:0] alu_rob_id,
  input  logic                       mul_valid,
  input  logic [WORD_SIZE-1:0]       mul_result,
  input  logic [ROB_ENTRY_WIDTH-1:0] mul_rob_id,
  input  logic                       mem_valid,
  input  logic [WORD_SIZE-1:0]       mem_result,
  input  logic [ROB_ENTRY_WIDTH-1:0] mem_rob_id,
  input  logic                       mem_exception,
  input  logic [WORD_SIZE-1:0]       mem_v_addr,
  input  logic [WORD_SIZE-1:0]       mem_pc,
  output logic                       alu_ready,
  output logic                       mul_ready,
  output logic                       mem_ready,
  output logic                       wb_valid,
  output logic [WORD_SIZE-1:0]       wb_result,
  output logic [ROB_ENTRY_WIDTH-1:0] wb_rob_id,
  output logic                       wb_exception,
  output logic [WORD_SIZE-1:0]       wb_v_addr,
  output logic [WORD_SIZE-1:0]       wb_pc,
  output logic [1:0]                 wb_src,
  output logic                       starve_err
);

  import wb_pkg::*;

  logic [NUM_WB_SOURCES-1:0]  valid_s;
  logic [NUM_WB_SOURCES-1:0]  req_s;
  logic [NUM_WB_SOURCES-1:0]  grant_s;
  logic                       grant_any_s;

  wb_src_t                    win_src_s;
  logic [WORD_SIZE-1:0]       win_result_s;
  logic [ROB_ENTRY_WIDTH-1:0] win_rob_id_s;
  logic                       win_exception_s;
  logic [WORD_SIZE-1:0]       win_v_addr_s;
  logic [WORD_SIZE-1:0]       win_pc_s;

  logic                       wb_valid_r;
  logic [WORD_SIZE-1:0]       wb_result_r;
  logic [ROB_ENTRY_WIDTH-1:0] wb_rob_id_r;
  logic                       wb_exception_r;
  logic [WORD_SIZE-1:0]       wb_v_addr_r;
  logic [WORD_SIZE-1:0]       wb_pc_r;
  wb_src_t                    wb_src_r;

  logic [1:0]                 wait_cnt_r [NUM_WB_SOURCES];
  logic [NUM_WB_SOURCES-1:0]  starve_hit_s;
  logic                       starve_r;

  // Bit order follows the wb_src_t encoding: ALU, MEM, MUL.
  assign valid_s     = {mul_valid, mem_valid, alu_valid};
  assign req_s       = valid_s & ~{NUM_WB_SOURCES{flush}};
  assign grant_any_s = |grant_s;

  rr_arbiter #(
    .N (NUM_WB_SOURCES)
  ) u_rr (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .req   (req_s),
    .grant (grant_s)
  );

  assign alu_ready = grant_s[0];
  assign mem_ready = grant_s[1];
  assign mul_ready = grant_s[2];

  // Select the winning payload; exception info is only carried for MEM.
  always_comb begin
    win_src_s       = grant_to_src(grant_s);
    win_result_s    = alu_result;
    win_rob_id_s    = alu_rob_id;
    win_exception_s = 1'b0;
    win_v_addr_s    = {WORD_SIZE{1'b0}};
    win_pc_s        = {WORD_SIZE{1'b0}};
    case (win_src_s)
      WB_SRC_ALU: begin
        win_result_s = alu_result;
        win_rob_id_s = alu_rob_id;
      end
      WB_SRC_MEM: begin
        win_result_s    = mem_result;
        win_rob_id_s    = mem_rob_id;
        win_exception_s = mem_exception;
        win_v_addr_s    = mem_v_addr;
        win_pc_s        = mem_pc;
      end
      WB_SRC_MUL: begin
        win_result_s = mul_result;
        win_rob_id_s = mul_rob_id;
      end
      default: begin
        win_result_s = alu_result;
        win_rob_id_s = alu_rob_id;
      end
    endcase
  end

  // Writeback register: pulse valid for one cycle per grant, hold payload otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid_r     <= 1'b0;
      wb_result_r    <= {WORD_SIZE{1'b0}};
      wb_rob_id_r    <= {ROB_ENTRY_WIDTH{1'b0}};
      wb_exception_r <= 1'b0;
      wb_v_addr_r    <= {WORD_SIZE{1'b0}};
      wb_pc_r        <= {WORD_SIZE{1'b0}};
      wb_src_r       <= WB_SRC_ALU;
    end else if (grant_any_s) begin
      wb_valid_r     <= 1'b1;
      wb_result_r    <= win_result_s;
      wb_rob_id_r    <= win_rob_id_s;
      wb_exception_r <= win_exception_s;
      wb_v_addr_r    <= win_v_addr_s;
      wb_pc_r        <= win_pc_s;
      wb_src_r       <= win_src_s;
    end else begin
      wb_valid_r     <= 1'b0;
    end
  end

  // A source is starving when denied again after already waiting WAIT_LIMIT cycles.
  always_comb begin
    starve_hit_s = {NUM_WB_SOURCES{1'b0}};
    for (int i = 0; i < NUM_WB_SOURCES; i++) begin
      starve_hit_s[i] = valid_s[i] && !grant_s[i] && (wait_cnt_r[i] == WAIT_LIMIT);
    end
  end

  // Saturating per-source wait counters and the sticky starvation flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_WB_SOURCES; i++) begin
        wait_cnt_r[i] <= 2'd0;
      end
      starve_r <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_WB_SOURCES; i++) begin
        if (valid_s[i] && !grant_s[i]) begin
          wait_cnt_r[i] <= (wait_cnt_r[i] == WAIT_LIMIT) ? WAIT_LIMIT : (wait_cnt_r[i] + 2'd1);
        end else begin
          wait_cnt_r[i] <= 2'd0;
        end
      end
      starve_r <= starve_r | (|starve_hit_s);
    end
  end

  assign wb_valid     = wb_valid_r;
  assign wb_result    = wb_result_r;
  assign wb_rob_id    = wb_rob_id_r;
  assign wb_exception = wb_exception_r;
  assign wb_v_addr    = wb_v_addr_r;
  assign wb_pc        = wb_pc_r;
  assign wb_src       = wb_src_r;
  assign starve_err   = starve_r;

  wb_arbiter_chk u_chk (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .valid        (valid_s),
    .ready        (grant_s),
    .wb_valid     (wb_valid_r),
    .wb_exception (wb_exception_r),
    .wb_src       (wb_src_r),
    .starve_err   (starve_r)
  );

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: the driver pushes expected writebacks into a
// scoreboard queue and a negedge monitor pops and compares them.
module tb_wb_arbiter;

  localparam int W  = 32;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          alu_valid = 1'b0, mul_valid = 1'b0, mem_valid = 1'b0;
  logic [W-1:0]  alu_result = '0, mul_result = '0, mem_result = '0;
  logic [RW-1:0] alu_rob_id = '0, mul_rob_id = '0, mem_rob_id = '0;
  logic          mem_exception = 1'b0;
  logic [W-1:0]  mem_v_addr = '0, mem_pc = '0;
  logic          alu_ready, mul_ready, mem_ready;
  logic          wb_valid, wb_exception, starve_err;
  logic [W-1:0]  wb_result, wb_v_addr, wb_pc;
  logic [RW-1:0] wb_rob_id;
  logic [1:0]    wb_src;

  typedef struct packed {
    logic [W-1:0]  result;
    logic [RW-1:0] rob_id;
    logic [1:0]    src;
    logic          exc;
    logic [W-1:0]  vaddr;
    logic [W-1:0]  pc;
  } wb_t;

  typedef struct {
    wb_t data;
    int  due;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  wb_t  mon_act;
  exp_t mon_exp;

  wb_arbiter #(.WORD_SIZE(W), .ROB_ENTRY_WIDTH(RW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alu_valid(alu_valid), .alu_result(alu_result), .alu_rob_id(alu_rob_id),
    .mul_valid(mul_valid), .mul_result(mul_result), .mul_rob_id(mul_rob_id),
    .mem_valid(mem_valid), .mem_result(mem_result), .mem_rob_id(mem_rob_id),
    .mem_exception(mem_exception), .mem_v_addr(mem_v_addr), .mem_pc(mem_pc),
    .alu_ready(alu_ready), .mul_ready(mul_ready), .mem_ready(mem_ready),
    .wb_valid(wb_valid), .wb_result(wb_result), .wb_rob_id(wb_rob_id),
    .wb_exception(wb_exception), .wb_v_addr(wb_v_addr), .wb_pc(wb_pc),
    .wb_src(wb_src), .starve_err(starve_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every wb_valid must match the oldest expectation, in its due cycle.
  always @(negedge clk) begin
    mon_act = {wb_result, wb_rob_id, wb_src, wb_exception, wb_v_addr, wb_pc};
    if (wb_valid) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected cyc=%0d act=%h", cyc, mon_act);
      end else begin
        mon_exp = sb_q.pop_front();
        if (mon_exp.due != cyc || mon_act !== mon_exp.data) begin
          errors++;
          $display("FAIL wb_payload cyc=%0d due=%0d act=%h exp=%h", cyc, mon_exp.due, mon_act, mon_exp.data);
        end
      end
    end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      checks++;
      errors++;
      mon_exp = sb_q.pop_front();
      $display("FAIL wb_missing cyc=%0d due=%0d exp=%h", cyc, mon_exp.due, mon_exp.data);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // One cycle: check readys mid-cycle, queue the expected writeback, advance.
  task automatic step(input logic [2:0] exp_rdy, input string tag);
    wb_t e;
    @(negedge clk);
    checks++;
    if ({mul_ready, mem_ready, alu_ready} !== exp_rdy) begin
      errors++;
      $display("FAIL %s ready act=%b exp=%b", tag, {mul_ready, mem_ready, alu_ready}, exp_rdy);
    end
    case (exp_rdy)
      3'b001: e = {alu_result, alu_rob_id, 2'd0, 1'b0, 32'd0, 32'd0};
      3'b010: e = {mem_result, mem_rob_id, 2'd1, mem_exception, mem_v_addr, mem_pc};
      3'b100: e = {mul_result, mul_rob_id, 2'd2, 1'b0, 32'd0, 32'd0};
      default: e = '0;
    endcase
    if (exp_rdy != 3'b000) sb_q.push_back('{data: e, due: cyc + 1});
    @(posedge clk);
    #1;
  endtask

  logic [2:0] rot_seq [6];

  initial begin
    rot_seq = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};

    #12;
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_result", 64'(wb_result), 64'd0);
    chk("rst_wb_src", 64'(wb_src), 64'd0);
    chk("rst_starve", 64'(starve_err), 64'd0);
    chk("rst_readys", 64'({mul_ready, mem_ready, alu_ready}), 64'd0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;

    // Single ALU request, latency one
    alu_valid = 1'b1; alu_result = 32'd15; alu_rob_id = 4'd2;
    step(3'b001, "alu_only");
    chk("alu_only_wb_valid", 64'(wb_valid), 64'd1);
    chk("alu_only_wb_result", 64'(wb_result), 64'd15);
    chk("alu_only_wb_rob", 64'(wb_rob_id), 64'd2);
    chk("alu_only_wb_src", 64'(wb_src), 64'd0);
    alu_valid = 1'b0;
    step(3'b000, "idle1");

    flush = 1'b1;
    step(3'b000, "flush_idle");
    flush = 1'b0;

    // All valid from pointer ALU: ALU, MEM, MUL, ALU
    alu_valid = 1'b1; alu_result = 32'd1; alu_rob_id = 4'd1;
    mem_valid = 1'b1; mem_result = 32'd2; mem_rob_id = 4'd2;
    mul_valid = 1'b1; mul_result = 32'd3; mul_rob_id = 4'd3;
    step(3'b001, "rot_alu");
    alu_result = 32'd4; alu_rob_id = 4'd4;
    step(3'b010, "rot_mem");
    mem_result = 32'd5; mem_rob_id = 4'd5;
    step(3'b100, "rot_mul");
    step(3'b001, "rot_alu2");
    alu_valid = 1'b0; mem_valid = 1'b0; mul_valid = 1'b0;
    step(3'b000, "idle2");

    // MEM exception payload, then ALU clears exception
    mem_valid = 1'b1; mem_result = 32'h77; mem_rob_id = 4'd7;
    mem_exception = 1'b1; mem_pc = 32'h40; mem_v_addr = 32'h100;
    step(3'b010, "mem_exc");
    chk("mem_exc_flag", 64'(wb_exception), 64'd1);
    chk("mem_exc_pc", 64'(wb_pc), 64'h40);
    chk("mem_exc_vaddr", 64'(wb_v_addr), 64'h100);
    chk("mem_exc_src", 64'(wb_src), 64'd1);
    mem_valid = 1'b0; mem_exception = 1'b0;
    alu_valid = 1'b1; alu_result = 32'd9; alu_rob_id = 4'd6;
    step(3'b001, "alu_after_exc");
    chk("alu_after_exc_flag", 64'(wb_exception), 64'd0);

    // Flush with everything valid
    alu_result = 32'd10; alu_rob_id = 4'd1;
    mem_valid = 1'b1; mem_result = 32'd11; mem_rob_id = 4'd2;
    mul_valid = 1'b1; mul_result = 32'd12; mul_rob_id = 4'd3;
    flush = 1'b1;
    step(3'b000, "flush_all");
    chk("flush_wb_valid", 64'(wb_valid), 64'd0);
    flush = 1'b0;
    step(3'b001, "post_flush_alu");
    alu_valid = 1'b0; mem_valid = 1'b0; mul_valid = 1'b0;
    step(3'b000, "idle3");

    // Pointer (MEM) holds while idle; payload holds too
    step(3'b000, "idle4");
    chk("hold_wb_result", 64'(wb_result), 64'd10);
    chk("hold_wb_valid", 64'(wb_valid), 64'd0);
    alu_valid = 1'b1; alu_result = 32'd20; alu_rob_id = 4'd2;
    mul_valid = 1'b1; mul_result = 32'd21; mul_rob_id = 4'd3;
    step(3'b100, "wrap_mul");
    mul_valid = 1'b0;
    step(3'b001, "wrap_alu");
    alu_valid = 1'b0;
    step(3'b000, "idle5");

    // Fair rotation never starves
    alu_valid = 1'b1; mem_valid = 1'b1; mul_valid = 1'b1;
    for (int i = 0; i < 6; i++) step(rot_seq[i], "rr_hold");
    chk("rr_no_starve", 64'(starve_err), 64'd0);
    alu_valid = 1'b0; mem_valid = 1'b0; mul_valid = 1'b0;
    step(3'b000, "idle6");

    // ALU denied by flush: 3 waits fine, 4th sets starve_err
    alu_valid = 1'b1; alu_result = 32'd30; alu_rob_id = 4'd4;
    flush = 1'b1;
    for (int i = 0; i < 3; i++) step(3'b000, "deny");
    chk("starve_after_3", 64'(starve_err), 64'd0);
    step(3'b000, "deny4");
    chk("starve_after_4", 64'(starve_err), 64'd1);
    flush = 1'b0;
    step(3'b001, "alu_after_starve");
    alu_valid = 1'b0;
    step(3'b000, "idle7");
    chk("starve_sticky", 64'(starve_err), 64'd1);

    // Async reset while wb_valid is high
    alu_valid = 1'b1; alu_result = 32'd40; alu_rob_id = 4'd5;
    step(3'b001, "pre_reset");
    alu_valid = 1'b0;
    chk("pre_reset_wb_valid", 64'(wb_valid), 64'd1);
    #6; rst = 1'b0; #1;
    chk("arst_wb_valid", 64'(wb_valid), 64'd0);
    chk("arst_wb_result", 64'(wb_result), 64'd0);
    chk("arst_wb_rob", 64'(wb_rob_id), 64'd0);
    chk("arst_wb_src", 64'(wb_src), 64'd0);
    chk("arst_starve", 64'(starve_err), 64'd0);
    chk("arst_exc_pc_va", 64'({wb_exception, wb_pc, wb_v_addr}), 64'd0);
    @(posedge clk); #1; rst = 1'b1;
    alu_valid = 1'b1; alu_result = 32'd50; alu_rob_id = 4'd1;
    mem_valid = 1'b1; mem_result = 32'd51; mem_rob_id = 4'd2;
    mul_valid = 1'b1; mul_result = 32'd52; mul_rob_id = 4'd3;
    step(3'b001, "post_reset_alu");
    alu_valid = 1'b0; mem_valid = 1'b0; mul_valid = 1'b0;
    step(3'b000, "idle8");
    step(3'b000, "idle9");
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default `WORD_SIZE, data/address width.
REQ-002 Parameter ROB_ENTRY_WIDTH, default `ROB_ENTRY_WIDTH, ROB id width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  pipeline flush (exception/mispredict); drops pending writeback.
REQ-006 alu_valid, alu_result, alu_rob_id  input  1/WORD_SIZE/ROB_ENTRY_WIDTH  ALU writeback request.
REQ-007 mul_valid, mul_result, mul_rob_id  input  1/WORD_SIZE/ROB_ENTRY_WIDTH  MUL writeback request.
REQ-008 mem_valid, mem_result, mem_rob_id, mem_exception, mem_v_addr, mem_pc  input  1/WORD_SIZE/ROB_ENTRY_WIDTH/1/WORD_SIZE/WORD_SIZE  MEM writeback request.
REQ-009 alu_ready, mul_ready, mem_ready  output  1 each  grant; request consumed on the cycle its ready is high.
REQ-010 wb_valid  output  1  registered writeback to ROB/bypass.
REQ-011 wb_result, wb_rob_id  output  WORD_SIZE/ROB_ENTRY_WIDTH  registered winning payload.
REQ-012 wb_exception, wb_v_addr, wb_pc  output  1/WORD_SIZE/WORD_SIZE  MEM exception info; 0 unless winner is MEM.
REQ-013 wb_src  output  2  winner encoding (ALU=0, MEM=1, MUL=2).
REQ-014 starve_err  output  1  sticky: a valid requester waited more than 3 consecutive cycles.

Function
REQ-015 At most one ready SHALL be high per cycle; ready is combinational from valids, priority pointer, flush.
REQ-016 Arbitration SHALL be round-robin over order ALU, MEM, MUL starting at pointer; after a grant the pointer SHALL move to the source after the winner.
REQ-017 With no valid requester, all readys SHALL be 0 and the pointer SHALL hold.
REQ-018 The granted payload SHALL appear on wb_* exactly one cycle after the grant cycle (latency 1), with wb_valid=1 for exactly one cycle per grant.
REQ-019 With no grant in a cycle, wb_valid SHALL be 0 next cycle; wb_result/wb_rob_id SHALL hold their previous values.
REQ-020 A requester SHALL hold valid and payload stable until it sees ready=1; the arbiter SHALL NOT latch unsampled requests.
REQ-021 flush=1 SHALL force all readys to 0 that cycle and wb_valid=0 next cycle; pointer SHALL reset to ALU.
REQ-022 Per-source wait counters (2-bit, saturating) SHALL increment while valid && !ready, clear on grant or !valid; reaching 3 with valid still high SHALL set starve_err until reset.
REQ-023 Simultaneous all-valid SHALL yield grants ALU, MEM, MUL, ALU... on consecutive cycles when pointer starts at ALU.
REQ-024 wb_exception SHALL equal mem_exception of the granted MEM request, else 0.

Reset
REQ-025 rst low SHALL asynchronously clear wb_valid, wb_result, wb_rob_id, wb_exception, wb_v_addr, wb_pc, wb_src, starve_err, wait counters, and set pointer to ALU.
REQ-026 Reset asserted mid-transfer SHALL discard the in-flight writeback; first grant after release follows REQ-016 from ALU.

Structure
REQ-027 Package wb_pkg SHALL hold the wb_src_t enum (ALU/MEM/MUL) and NUM_WB_SOURCES=3.
REQ-028 Sub-module rr_arbiter (parameterised N-way round-robin, request vector in, one-hot grant out, pointer register inside) SHALL implement REQ-016/017.

Verification
REQ-029 Reset, only alu_valid=1, alu_result=15, alu_rob_id=2 -> alu_ready=1 same cycle; next cycle wb_valid=1, wb_result=15, wb_rob_id=2, wb_src=0.
REQ-030 All three valid for 3 cycles (results 1,2,3) -> grants ALU, MEM, MUL in order; wb_result 1,2,3 on following cycles.
REQ-031 MEM only, mem_exception=1, mem_pc=0x40, mem_v_addr=0x100 -> wb_exception=1, wb_pc=0x40, wb_v_addr=0x100, wb_src=1; next ALU grant shows wb_exception=0.
REQ-032 All valid, flush=1 one cycle -> no ready that cycle, wb_valid=0 next cycle, next grant is ALU.
REQ-033 MEM and MUL held valid, ALU valid held but only granted per rotation -> starve_err stays 0; force ALU denied 4 cycles (hold pointer via backdoor) -> starve_err=1.
REQ-034 rst low while wb_valid=1 -> all outputs 0 immediately, without clock edge.
